// File: rtl/pcs_side_stream_scrambler.sv
// pcs_side_stream_scrambler: 1000BASE-T side-stream scrambler producing STEPS Sx/Sy/Sg nibble sets per clock
module pcs_side_stream_scrambler #(
  parameter int          STEPS      = 1,
  parameter logic [32:0] RESET_SEED = 33'h1,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_master,
  input  logic                 io_load,
  input  logic [32:0]          io_seed,
  input  logic                 io_advance,
  output logic                 io_valid,
  output logic [4*STEPS-1:0]   io_sx,
  output logic [4*STEPS-1:0]   io_sy,
  output logic [4*STEPS-1:0]   io_sg,
  output logic [32:0]          io_state
);
  logic [32:0]        scr [0:STEPS];
  logic [4*STEPS-1:0] sx, sy, sg;
  logic [32:0]        load_val;
  assign scr[0]   = io_state;
  assign load_val = (ZERO_GUARD && io_seed == '0) ? 33'h1 : io_seed;
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    logic [32:0] c;
    assign c = {scr[k][31:0], scr[k][32] ^ (io_master ? scr[k][12] : scr[k][19])};
    assign scr[k+1] = c;
    assign sy[4*k +: 4] = {c[9] ^ c[14] ^ c[19] ^ c[24], c[6] ^ c[16], c[3] ^ c[8], c[0]};
    assign sx[4*k +: 4] = {c[13] ^ c[15] ^ c[18] ^ c[20] ^ c[23] ^ c[25] ^ c[28] ^ c[30],
                           c[10] ^ c[12] ^ c[20] ^ c[22], c[7] ^ c[9] ^ c[12] ^ c[14], c[4] ^ c[6]};
    assign sg[4*k +: 4] = {c[10] ^ c[14] ^ c[19] ^ c[23] ^ c[26] ^ c[30],
                           c[7] ^ c[11] ^ c[17] ^ c[21], c[4] ^ c[8] ^ c[9] ^ c[13], c[1] ^ c[5]};
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      io_state <= RESET_SEED;
      io_valid <= 1'b0;
      io_sx    <= '0;
      io_sy    <= '0;
      io_sg    <= '0;
    end else begin
      io_valid <= io_advance && !io_load;
      if (io_load) begin
        io_state <= load_val;
      end else if (io_advance) begin
        io_state <= scr[STEPS];
        io_sx    <= sx;
        io_sy    <= sy;
        io_sg    <= sg;
      end
    end
  end
endmodule

// File: tb/tb_pcs_side_stream_scrambler.sv
// tb_pcs_side_stream_scrambler: scoreboard bench for a 1-step guarded and a 4-step unguarded scrambler
module tb_pcs_side_stream_scrambler;
  typedef struct packed {
    logic [32:0] s1;
    logic [3:0]  x1, y1, g1;
    logic        v1;
    logic [32:0] s4;
    logic [15:0] x4, y4, g4;
    logic        v4;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_master = 1'b0;
  logic        io_load = 1'b0;
  logic [32:0] io_seed = '0;
  logic        io_advance = 1'b0;
  logic        v1, v4;
  logic [3:0]  sx1, sy1, sg1;
  logic [15:0] sx4, sy4, sg4;
  logic [32:0] st1, st4;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        mdl;
  always #5 clock = ~clock;
  pcs_side_stream_scrambler #(.STEPS(1), .RESET_SEED(33'h1), .ZERO_GUARD(1'b1)) dut1 (
    .clock(clock), .reset(reset), .io_master(io_master), .io_load(io_load), .io_seed(io_seed),
    .io_advance(io_advance), .io_valid(v1), .io_sx(sx1), .io_sy(sy1), .io_sg(sg1), .io_state(st1)
  );
  pcs_side_stream_scrambler #(.STEPS(4), .RESET_SEED(33'h1), .ZERO_GUARD(1'b0)) dut4 (
    .clock(clock), .reset(reset), .io_master(io_master), .io_load(io_load), .io_seed(io_seed),
    .io_advance(io_advance), .io_valid(v4), .io_sx(sx4), .io_sy(sy4), .io_sg(sg4), .io_state(st4)
  );
  function automatic logic [32:0] mstep(input logic [32:0] s, input logic m);
    return {s[31:0], s[32] ^ (m ? s[12] : s[19])};
  endfunction
  function automatic logic [11:0] nib(input logic [32:0] c);
    logic [3:0] x, y, g;
    y[0] = c[0];
    y[1] = c[3] ^ c[8];
    y[2] = c[6] ^ c[16];
    y[3] = c[9] ^ c[14] ^ c[19] ^ c[24];
    x[0] = c[4] ^ c[6];
    x[1] = c[7] ^ c[9] ^ c[12] ^ c[14];
    x[2] = c[10] ^ c[12] ^ c[20] ^ c[22];
    x[3] = c[13] ^ c[15] ^ c[18] ^ c[20] ^ c[23] ^ c[25] ^ c[28] ^ c[30];
    g[0] = c[1] ^ c[5];
    g[1] = c[4] ^ c[8] ^ c[9] ^ c[13];
    g[2] = c[7] ^ c[11] ^ c[17] ^ c[21];
    g[3] = c[10] ^ c[14] ^ c[19] ^ c[23] ^ c[26] ^ c[30];
    return {x, y, g};
  endfunction
  task automatic drive(input bit rn, input bit ld, input bit adv, input bit mst, input logic [32:0] sd);
    logic [11:0] n;
    @(negedge clock);
    reset = rn;
    io_load = ld;
    io_advance = adv;
    io_master = mst;
    io_seed = sd;
    if (!rn) begin
      mdl = '0;
      mdl.s1 = 33'h1;
      mdl.s4 = 33'h1;
    end else if (ld) begin
      mdl.s1 = (sd == '0) ? 33'h1 : sd;
      mdl.s4 = sd;
      mdl.v1 = 1'b0;
      mdl.v4 = 1'b0;
    end else if (adv) begin
      mdl.s1 = mstep(mdl.s1, mst);
      n = nib(mdl.s1);
      {mdl.x1, mdl.y1, mdl.g1} = n;
      mdl.v1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
        mdl.s4 = mstep(mdl.s4, mst);
        n = nib(mdl.s4);
        mdl.x4[4*k +: 4] = n[11:8];
        mdl.y4[4*k +: 4] = n[7:4];
        mdl.g4[4*k +: 4] = n[3:0];
      end
      mdl.v4 = 1'b1;
    end else begin
      mdl.v1 = 1'b0;
      mdl.v4 = 1'b0;
    end
    sb.push_back(mdl);
    @(posedge clock);
    #2;
  endtask
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (st1 !== e.s1) begin errors++; $display("FAIL sb_state1 got %h exp %h", st1, e.s1); end
      checks++; if (sx1 !== e.x1) begin errors++; $display("FAIL sb_sx1 got %h exp %h", sx1, e.x1); end
      checks++; if (sy1 !== e.y1) begin errors++; $display("FAIL sb_sy1 got %h exp %h", sy1, e.y1); end
      checks++; if (sg1 !== e.g1) begin errors++; $display("FAIL sb_sg1 got %h exp %h", sg1, e.g1); end
      checks++; if (v1 !== e.v1) begin errors++; $display("FAIL sb_valid1 got %b exp %b", v1, e.v1); end
      checks++; if (st4 !== e.s4) begin errors++; $display("FAIL sb_state4 got %h exp %h", st4, e.s4); end
      checks++; if (sx4 !== e.x4) begin errors++; $display("FAIL sb_sx4 got %h exp %h", sx4, e.x4); end
      checks++; if (sy4 !== e.y4) begin errors++; $display("FAIL sb_sy4 got %h exp %h", sy4, e.y4); end
      checks++; if (sg4 !== e.g4) begin errors++; $display("FAIL sb_sg4 got %h exp %h", sg4, e.g4); end
      checks++; if (v4 !== e.v4) begin errors++; $display("FAIL sb_valid4 got %b exp %b", v4, e.v4); end
    end
  end
  task automatic test_reset();
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    checks++; if (st1 !== 33'h1) begin errors++; $display("FAIL reset_state got %h exp 1", st1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v1); end
    checks++; if ({sx4, sy4, sg4} !== '0) begin errors++; $display("FAIL reset_nibbles got %h exp 0", {sx4, sy4, sg4}); end
  endtask
  task automatic test_master();
    drive(0, 0, 0, 0, '0);
    for (int i = 1; i <= 13; i++) begin
      drive(1, 0, 1, 1, '0);
      checks++;
      if (st1 !== ((i == 13) ? 33'h2001 : (33'h1 << i))) begin
        errors++; $display("FAIL master_state cycle %0d got %h", i, st1);
      end
      checks++;
      if (sy1[0] !== (i == 13)) begin errors++; $display("FAIL master_sy0 cycle %0d got %b", i, sy1[0]); end
    end
  endtask
  task automatic test_slave();
    drive(0, 0, 0, 0, '0);
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 1, 0, '0);
      if (i == 13) begin
        checks++; if (st1 !== 33'h2000) begin errors++; $display("FAIL slave_state13 got %h exp 2000", st1); end
      end
      if (i == 20) begin
        checks++; if (st1 !== 33'h100001) begin errors++; $display("FAIL slave_state20 got %h exp 100001", st1); end
      end
    end
  endtask
  task automatic test_multistep();
    logic [32:0] exp4 [4] = '{33'h10, 33'h100, 33'h1000, 33'h10008};
    drive(0, 0, 0, 0, '0);
    for (int j = 0; j < 4; j++) begin
      drive(1, 0, 1, 1, '0);
      checks++; if (st4 !== exp4[j]) begin errors++; $display("FAIL multi_state adv %0d got %h exp %h", j, st4, exp4[j]); end
      checks++;
      if ((sy4 & 16'h1111) !== ((j == 3) ? 16'h0001 : 16'h0000)) begin
        errors++; $display("FAIL multi_sy0_lanes adv %0d got %h", j, sy4 & 16'h1111);
      end
    end
  endtask
  task automatic test_load();
    drive(1, 1, 1, 1, '0);
    checks++; if (st1 !== 33'h1) begin errors++; $display("FAIL load_zero_guard got %h exp 1", st1); end
    checks++; if (st4 !== 33'h0) begin errors++; $display("FAIL load_zero_noguard got %h exp 0", st4); end
    drive(1, 1, 1, 1, 33'h1_2345_6789);
    checks++; if (st1 !== 33'h1_2345_6789) begin errors++; $display("FAIL load_adv_state got %h exp 123456789", st1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL load_adv_valid got %b exp 0", v1); end
    drive(1, 0, 1, 0, '0);
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, '0);
      checks++;
      if ({st4, sx4, sy4, sg4} !== '0) begin errors++; $display("FAIL lockup_zero got %h exp 0", {st4, sx4, sy4, sg4}); end
    end
  endtask
  task automatic test_gaps();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, pat[i], 1, '0);
      checks++; if (v1 !== pat[i]) begin errors++; $display("FAIL gap_valid %0d got %b exp %b", i, v1, pat[i]); end
      checks++;
      if (st1 !== ((i == 3) ? 33'h4 : 33'h2)) begin errors++; $display("FAIL gap_state %0d got %h", i, st1); end
    end
  endtask
  task automatic test_reset_mid();
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 1, '0);
    drive(0, 1, 1, 1, 33'h5);
    checks++; if (st1 !== 33'h1 || st4 !== 33'h1) begin errors++; $display("FAIL midreset_state got %h/%h exp 1", st1, st4); end
    checks++; if (v1 !== 1'b0 || v4 !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b/%b exp 0", v1, v4); end
    checks++; if ({sx1, sy1, sg1} !== '0) begin errors++; $display("FAIL midreset_nibbles got %h exp 0", {sx1, sy1, sg1}); end
    drive(1, 0, 1, 1, '0);
    checks++; if (st1 !== 33'h2 || v1 !== 1'b1) begin errors++; $display("FAIL resume got %h/%b exp 2/1", st1, v1); end
  endtask
  task automatic test_random();
    logic [63:0] r;
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 60; i++) begin
      r = {$urandom(), $urandom()};
      drive(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), r[40], r[32:0]);
    end
  endtask
  initial begin
    test_reset();
    test_master();
    test_slave();
    test_multistep();
    test_load();
    test_gaps();
    test_reset_mid();
    test_random();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
